datamemory_hs: RTL

//  Parametrised RV32I data memory with valid/ready request and response channels.

---
 rtl/datamemory_hs_if.sv | 26 ++
 rtl/datamemory_hs.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/datamemory_hs_if.sv
// Request/response bundle between the MEM stage (master) and the data memory (slave).
// Both channels use valid/ready handshakes; the slave holds one request at a time.
interface datamemory_hs_if #(
  parameter int ADDR_W = 12
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/datamemory_hs.sv
// RV32I data memory behind a valid/ready request/response pair.
// Stores complete on the accept edge with byte-lane steering; loads return sign/zero
// extended data after RD_LATENCY cycles. Misaligned, illegal-funct3 and out-of-range
// accesses are rejected at accept without touching the array and answered with rsp_err.
module datamemory_hs #(
  parameter int    ADDR_W      = 12,
  parameter int    DEPTH_WORDS = 1024,
  parameter int    RD_LATENCY  = 1,
  parameter string INIT_FILE   = ""
) (
  input  logic            clk,
  input  logic            reset_n,
  datamemory_hs_if.slave  bus
);

  localparam int IDX_W  = ADDR_W - 2;
  localparam int MEM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // ACCESS runs RD_LATENCY-1 cycles; the counter counts down to zero in the last one.
  localparam logic [1:0] CNT_INIT = (RD_LATENCY > 1) ? 2'(RD_LATENCY - 2) : 2'd0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACCESS = 2'b01,
    S_RESP   = 2'b10
  } state_t;

  // ------------------------------------------------------------------
  // Helper functions
  // ------------------------------------------------------------------

  // Any reason to reject the access: alignment, unsupported funct3 or word index past the array.
  function automatic logic access_err(input logic we, input logic [2:0] f3,
                                      input logic [ADDR_W-1:0] addr);
    logic misaligned;
    logic illegal;
    logic out_of_range;
    misaligned   = ((f3[1:0] == 2'b01) && (addr[0] != 1'b0)) ||
                   ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    if (we) begin
      illegal = (f3 > 3'b010);
    end else begin
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    out_of_range = ({{(32-IDX_W){1'b0}}, addr[ADDR_W-1:2]} >= 32'(DEPTH_WORDS));
    return misaligned | illegal | out_of_range;
  endfunction

  // Byte-lane enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] be;
    case (f3)
      3'b000:  be = 4'b0001 << off;
      3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
      3'b010:  be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate the LSB-aligned store data so every enabled lane sees its byte.
  function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] lanes;
    case (f3)
      3'b000:  lanes = {4{wd[7:0]}};
      3'b001:  lanes = {2{wd[15:0]}};
      default: lanes = wd;
    endcase
    return lanes;
  endfunction

  // Little-endian byte select followed by sign or zero extension.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [31:0] sh;
    logic [31:0] res;
    sh = w >> {off, 3'b000};
    case (f3)
      3'b000:  res = {{24{sh[7]}}, sh[7:0]};
      3'b001:  res = {{16{sh[15]}}, sh[15:0]};
      3'b010:  res = w;
      3'b100:  res = {24'h000000, sh[7:0]};
      3'b101:  res = {16'h0000, sh[15:0]};
      default: res = 32'h00000000;
    endcase
    return res;
  endfunction

  // ------------------------------------------------------------------
  // Storage
  // ------------------------------------------------------------------
  logic [31:0] mem_r [0:DEPTH_WORDS-1];

  // ------------------------------------------------------------------
  // State and decode signals
  // ------------------------------------------------------------------
  state_t      state_r,      state_nxt_s;
  logic [1:0]  cnt_r,        cnt_nxt_s;
  logic        req_ready_r,  req_ready_nxt_s;
  logic        rsp_valid_r,  rsp_valid_nxt_s;
  logic [31:0] rsp_rdata_r,  rsp_rdata_nxt_s;
  logic        rsp_err_r,    rsp_err_nxt_s;
  logic [2:0]  cap_funct3_r, cap_funct3_nxt_s;
  logic [1:0]  cap_off_r,    cap_off_nxt_s;
  logic [31:0] rd_word_r,    rd_word_nxt_s;

  logic              accept_s;
  logic              req_err_s;
  logic              store_fire_s;
  logic [IDX_W-1:0]  idx_s;
  logic [MEM_AW-1:0] mem_idx_s;
  logic [3:0]        be_s;
  logic [31:0]       wlane_s;
  logic [31:0]       rd_word_s;

  // Request decode: handshake, error classification, store lanes and the addressed word.
  always_comb begin
    idx_s        = bus.req_addr[ADDR_W-1:2];
    mem_idx_s    = idx_s[MEM_AW-1:0];
    // Nothing is accepted while reset is held, so no store can slip into the array.
    accept_s     = bus.req_valid & req_ready_r & reset_n;
    req_err_s    = access_err(bus.req_we, bus.req_funct3, bus.req_addr);
    store_fire_s = accept_s & bus.req_we & ~req_err_s;
    be_s         = store_be(bus.req_funct3, bus.req_addr[1:0]);
    wlane_s      = store_lanes(bus.req_funct3, bus.req_wdata);
    rd_word_s    = mem_r[mem_idx_s];
  end

  // Array write port: enabled lanes are updated on the store's accept edge.
  always_ff @(posedge clk) begin
    if (store_fire_s) begin
      for (int b = 0; b < 4; b++) begin
        if (be_s[b]) begin
          mem_r[mem_idx_s][8*b +: 8] <= wlane_s[8*b +: 8];
        end
      end
    end
  end

  // Next-state and next-output logic for the IDLE -> ACCESS -> RESP sequence.
  always_comb begin
    state_nxt_s      = state_r;
    cnt_nxt_s        = cnt_r;
    rsp_valid_nxt_s  = rsp_valid_r;
    rsp_rdata_nxt_s  = rsp_rdata_r;
    rsp_err_nxt_s    = rsp_err_r;
    cap_funct3_nxt_s = cap_funct3_r;
    cap_off_nxt_s    = cap_off_r;
    rd_word_nxt_s    = rd_word_r;

    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          cap_funct3_nxt_s = bus.req_funct3;
          cap_off_nxt_s    = bus.req_addr[1:0];
          if (req_err_s) begin
            state_nxt_s     = S_RESP;
            rsp_valid_nxt_s = 1'b1;
            rsp_rdata_nxt_s = 32'h00000000;
            rsp_err_nxt_s   = 1'b1;
          end else if (bus.req_we) begin
            state_nxt_s     = S_RESP;
            rsp_valid_nxt_s = 1'b1;
            rsp_rdata_nxt_s = 32'h00000000;
            rsp_err_nxt_s   = 1'b0;
          end else if (RD_LATENCY == 1) begin
            state_nxt_s     = S_RESP;
            rsp_valid_nxt_s = 1'b1;
            rsp_rdata_nxt_s = load_ext(rd_word_s, bus.req_funct3, bus.req_addr[1:0]);
            rsp_err_nxt_s   = 1'b0;
          end else begin
            // Word is sampled now; later stores cannot overlap since one request is outstanding.
            state_nxt_s   = S_ACCESS;
            cnt_nxt_s     = CNT_INIT;
            rd_word_nxt_s = rd_word_s;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_ACCESS: begin
        if (cnt_r == 2'd0) begin
          state_nxt_s     = S_RESP;
          rsp_valid_nxt_s = 1'b1;
          rsp_rdata_nxt_s = load_ext(rd_word_r, cap_funct3_r, cap_off_r);
          rsp_err_nxt_s   = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r - 2'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s     = S_IDLE;
          rsp_valid_nxt_s = 1'b0;
          rsp_rdata_nxt_s = 32'h00000000;
          rsp_err_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = S_RESP;
        end
      end
      default: begin
        state_nxt_s     = S_IDLE;
        cnt_nxt_s       = 2'd0;
        rsp_valid_nxt_s = 1'b0;
        rsp_rdata_nxt_s = 32'h00000000;
        rsp_err_nxt_s   = 1'b0;
      end
    endcase

    req_ready_nxt_s = (state_nxt_s == S_IDLE);
  end

  // State, counter, capture and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= S_IDLE;
      cnt_r        <= 2'd0;
      req_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_rdata_r  <= 32'h00000000;
      rsp_err_r    <= 1'b0;
      cap_funct3_r <= 3'b000;
      cap_off_r    <= 2'b00;
      rd_word_r    <= 32'h00000000;
    end else begin
      state_r      <= state_nxt_s;
      cnt_r        <= cnt_nxt_s;
      req_ready_r  <= req_ready_nxt_s;
      rsp_valid_r  <= rsp_valid_nxt_s;
      rsp_rdata_r  <= rsp_rdata_nxt_s;
      rsp_err_r    <= rsp_err_nxt_s;
      cap_funct3_r <= cap_funct3_nxt_s;
      cap_off_r    <= cap_off_nxt_s;
      rd_word_r    <= rd_word_nxt_s;
    end
  end

  assign bus.req_ready = req_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;

endmodule
